// File: rtl/mem_stage_ctrl.sv
// Memory-access stage controller: drives a request/acknowledge data-memory
// port, stalls the front of the pipeline while an access is outstanding,
// holds the MEM/WB pipeline register and flags misaligned or timed-out
// accesses with a sticky error bit.
module mem_stage_ctrl #(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wb_i,
    input  logic [1:0]  mem_i,
    input  logic [31:0] alu_res_i,
    input  logic [31:0] store_data_i,
    input  logic [4:0]  rd_addr_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        stall_o,
    output logic        wb_o,
    output logic [4:0]  rd_addr_o,
    output logic [31:0] wb_data_o,
    output logic        err_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] MAX_CNT = 8'(MAX_WAIT);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q;
    logic [7:0]  cnt_nxt;
    logic        mem_op;
    logic        misaligned;
    logic        timeout;
    logic        stall_raw;

    logic        req_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] cap_q;
    logic        err_q;

    // MEM/WB pipeline register
    logic        wb_p1;
    logic [4:0]  rd_p1;
    logic [31:0] wb_data_p1;

    assign mem_op     = |mem_i;
    assign misaligned = |alu_res_i[1:0];
    assign cnt_nxt    = cnt_q + 8'd1;
    assign timeout    = (state_q == BUSY) && !mem_ack_i && (cnt_nxt == MAX_CNT);

    // Next-state decode and the combinational stall toward the front end
    always_comb begin
        state_d   = state_q;
        stall_raw = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_op) begin
                    stall_raw = 1'b1;
                    state_d   = misaligned ? DONE : BUSY;
                end
            end
            BUSY: begin
                stall_raw = 1'b1;
                if (mem_ack_i || timeout) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // The op is still presented on mem_i here; returning to IDLE
                // lets EX/MEM advance before the next op is looked at.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Stall is released while reset is held so a frozen front end cannot
    // depend on a stale EX/MEM op.
    assign stall_o = rst_i & stall_raw;

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Memory port: latch the access on launch, hold it for the whole request,
    // count wait cycles and capture load data or the error outcome
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cap_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mem_op) begin
                        addr_q  <= alu_res_i;
                        wdata_q <= store_data_i;
                        we_q    <= mem_i[0];
                        cnt_q   <= '0;
                        if (misaligned) begin
                            err_q <= 1'b1;
                            cap_q <= '0;
                        end else begin
                            req_q <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (mem_ack_i) begin
                        req_q <= 1'b0;
                        cnt_q <= '0;
                        if (!we_q) begin
                            cap_q <= mem_rdata_i;
                        end
                    end else if (timeout) begin
                        req_q <= 1'b0;
                        cnt_q <= '0;
                        err_q <= 1'b1;
                        cap_q <= '0;
                    end else begin
                        cnt_q <= cnt_nxt;
                    end
                end
                default: begin
                    req_q <= 1'b0;
                end
            endcase
        end
    end

    // MEM/WB register: pass-through for ALU ops, bubbles while stalled,
    // write-back value selected on the DONE edge
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wb_p1      <= 1'b0;
            rd_p1      <= '0;
            wb_data_p1 <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mem_op) begin
                        wb_p1 <= 1'b0;
                    end else begin
                        wb_p1      <= wb_i;
                        rd_p1      <= rd_addr_i;
                        wb_data_p1 <= alu_res_i;
                    end
                end
                BUSY: begin
                    wb_p1 <= 1'b0;
                end
                DONE: begin
                    wb_p1      <= wb_i;
                    rd_p1      <= rd_addr_i;
                    wb_data_p1 <= we_q ? alu_res_i : cap_q;
                end
                default: begin
                    wb_p1 <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req_o   = req_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign err_o       = err_q;
    assign wb_o        = wb_p1;
    assign rd_addr_o   = rd_p1;
    assign wb_data_o   = wb_data_p1;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: table-driven ALU pass-through vectors plus
// hand-written memory sequences; MEM/WB results go through a scoreboard queue.
module tb_mem_stage_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        wb_i = 1'b0;
    logic [1:0]  mem_i = '0;
    logic [31:0] alu_res_i = '0;
    logic [31:0] store_data_i = '0;
    logic [4:0]  rd_addr_i = '0;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic        stall_o;
    logic        wb_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] wb_data_o;
    logic        err_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        wb;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic        ack;
        logic        exp_wb;
        logic [4:0]  exp_rd;
        logic [31:0] exp_data;
    } vec_t;

    typedef struct {
        logic        wb;
        logic [4:0]  rd;
        logic [31:0] data;
    } wbexp_t;

    vec_t   vecs[5];
    wbexp_t sb[$];

    mem_stage_ctrl #(.MAX_WAIT(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .wb_i(wb_i), .mem_i(mem_i),
        .alu_res_i(alu_res_i), .store_data_i(store_data_i), .rd_addr_i(rd_addr_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .stall_o(stall_o), .wb_o(wb_o), .rd_addr_o(rd_addr_o),
        .wb_data_o(wb_data_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic pop_check(input string tag);
        wbexp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_sb: got empty queue expected an entry", tag);
        end else begin
            e = sb.pop_front();
            check({tag, "_wb"}, wb_o, e.wb);
            check({tag, "_rd"}, rd_addr_o, e.rd);
            check({tag, "_data"}, wb_data_o, e.data);
        end
    endtask

    // Entered just after a rising edge; returns just after the next one.
    task automatic run_alu(input string tag, input vec_t v);
        mem_i     = 2'b00;
        wb_i      = v.wb;
        rd_addr_i = v.rd;
        alu_res_i = v.alu;
        mem_ack_i = v.ack;
        #1;
        check({tag, "_stall"}, stall_o, 0);
        check({tag, "_req"}, mem_req_o, 0);
        sb.push_back('{v.exp_wb, v.exp_rd, v.exp_data});
        @(posedge clk_i); #1;
        mem_ack_i = 1'b0;
        pop_check(tag);
    endtask

    // One memory op; ack_at = index of the request cycle that gets the ack
    // (0 = never acknowledge).
    task automatic run_mem(input string tag, input logic [1:0] m, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [4:0] rd, input logic wbv,
                           input int ack_at, input logic [31:0] rdata, input int exp_req,
                           input int exp_stall, input logic exp_wb, input logic [31:0] exp_data);
        int   req_n = 0;
        int   stall_n = 0;
        int   cyc = 0;
        bit   done = 0;
        bit   prev_stall = 0;
        mem_i        = m;
        alu_res_i    = addr;
        store_data_i = wd;
        rd_addr_i    = rd;
        wb_i         = wbv;
        mem_rdata_i  = rdata;
        mem_ack_i    = 1'b0;
        while (!done && cyc < 40) begin
            #1;
            if (prev_stall) check({tag, "_bubble"}, wb_o, 0);
            if (mem_req_o) begin
                req_n++;
                check({tag, "_we"}, mem_we_o, m[0]);
                check({tag, "_addr"}, mem_addr_o, addr);
                check({tag, "_wdata"}, mem_wdata_o, wd);
            end
            if (stall_o) begin
                stall_n++;
                prev_stall = 1;
                mem_ack_i = mem_req_o && (req_n == ack_at);
                @(posedge clk_i); #1;
                mem_ack_i = 1'b0;
            end else begin
                sb.push_back('{exp_wb, rd, exp_data});
                @(posedge clk_i); #1;
                pop_check(tag);
                done = 1;
            end
            cyc++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_finish: got no completion within 40 cycles expected completion", tag);
        end
        check({tag, "_req_cycles"}, req_n, exp_req);
        check({tag, "_stall_cycles"}, stall_n, exp_stall);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 5'd5,  32'h0000_0010, 1'b0, 1'b1, 5'd5,  32'h0000_0010};
        vecs[1] = '{1'b0, 5'd3,  32'hFFFF_FFFF, 1'b0, 1'b0, 5'd3,  32'hFFFF_FFFF};
        vecs[2] = '{1'b1, 5'd31, 32'h8000_0001, 1'b1, 1'b1, 5'd31, 32'h8000_0001};
        vecs[3] = '{1'b1, 5'd0,  32'hA5A5_5A5A, 1'b0, 1'b1, 5'd0,  32'hA5A5_5A5A};
        vecs[4] = '{1'b1, 5'd12, 32'h0000_0013, 1'b1, 1'b1, 5'd12, 32'h0000_0013};

        // Reset values
        #12;
        check("rst_req", mem_req_o, 0);
        check("rst_we", mem_we_o, 0);
        check("rst_stall", stall_o, 0);
        check("rst_wb", wb_o, 0);
        check("rst_err", err_o, 0);
        check("rst_addr", mem_addr_o, 0);
        check("rst_wdata", mem_wdata_o, 0);
        check("rst_rd", rd_addr_o, 0);
        check("rst_wbdata", wb_data_o, 0);
        rst_i = 1'b1;
        @(posedge clk_i); #1;

        for (int i = 0; i < 5; i++) run_alu($sformatf("alu%0d", i), vecs[i]);

        run_mem("load", 2'b10, 32'h0000_0040, 32'h0, 5'd7, 1'b1, 1, 32'hDEAD_BEEF,
                1, 2, 1'b1, 32'hDEAD_BEEF);
        run_mem("store", 2'b01, 32'h0000_0080, 32'h0000_1234, 5'd9, 1'b0, 3, 32'hCAFE_F00D,
                3, 4, 1'b0, 32'h0000_0080);
        run_alu("alu_after_store", vecs[0]);
        run_mem("rw11", 2'b11, 32'h0000_0084, 32'h0000_7777, 5'd2, 1'b0, 1, 32'h0000_9999,
                1, 2, 1'b0, 32'h0000_0084);
        check("err_before_misalign", err_o, 0);
        run_mem("misalign", 2'b10, 32'h0000_0042, 32'h0, 5'd4, 1'b1, 0, 32'h5555_AAAA,
                0, 1, 1'b1, 32'h0);
        check("err_misalign", err_o, 1);

        // Reset in the second BUSY cycle
        mem_i = 2'b10; alu_res_i = 32'h0000_0100; rd_addr_i = 5'd8; wb_i = 1'b1;
        @(posedge clk_i); #1;
        check("rmid_busy1_req", mem_req_o, 1);
        @(posedge clk_i); #1;
        check("rmid_busy2_req", mem_req_o, 1);
        #2 rst_i = 1'b0;
        #1;
        check("rmid_req_drop", mem_req_o, 0);
        check("rmid_stall_drop", stall_o, 0);
        mem_i = 2'b00; wb_i = 1'b0; rd_addr_i = '0; alu_res_i = '0;
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check("rmid_err", err_o, 0);
        check("rmid_wb", wb_o, 0);
        check("rmid_rd", rd_addr_o, 0);
        check("rmid_wbdata", wb_data_o, 0);
        check("rmid_addr", mem_addr_o, 0);
        check("rmid_we", mem_we_o, 0);
        check("rmid_stall", stall_o, 0);
        @(posedge clk_i); #1;
        run_alu("alu_after_reset", vecs[4]);

        run_mem("timeout", 2'b10, 32'h0000_0200, 32'h0, 5'd6, 1'b1, 0, 32'h1111_2222,
                4, 5, 1'b1, 32'h0);
        check("err_timeout", err_o, 1);
        run_alu("alu_after_timeout", vecs[3]);
        check("err_sticky", err_o, 1);

        mem_i = 2'b00;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
